// File: rtl/mem_access_seq_pkg.sv
// Shared types and constants for the byte-serial data-memory access sequencer.
package mem_seq_pkg;

  localparam int unsigned NB = 4;

  // Size field encodes bytes minus one
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

endpackage

// File: rtl/mem_access_seq_if.sv
// Byte-wide data-memory port: base address + 2-bit offset, write enable, write/read data.
interface mem_access_seq_if #(
  parameter int unsigned W = 8,
  parameter int unsigned A = 8
);
  logic [A-1:0] MemAddress;
  logic [1:0]   MemOffset;
  logic         MemWriteEn;
  logic [W-1:0] MemWrData;
  logic [W-1:0] MemRdData;

  modport master (
    output MemAddress,
    output MemOffset,
    output MemWriteEn,
    output MemWrData,
    input  MemRdData
  );

  modport slave (
    input  MemAddress,
    input  MemOffset,
    input  MemWriteEn,
    input  MemWrData,
    output MemRdData
  );
endinterface

// File: rtl/data_mem.sv
// Byte-wide data memory: address = base + offset (wraps modulo 2^A), combinational read.
module data_mem #(
  parameter int unsigned W = 8,
  parameter int unsigned A = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  mem_access_seq_if.slave   mem
);
  localparam int unsigned DEPTH = 1 << A;

  logic [W-1:0] core [DEPTH];
  logic [A-1:0] addr;

  always_comb begin
    addr          = mem.MemAddress + A'(mem.MemOffset);
    mem.MemRdData = core[addr];
  end

  // Reset preloads each location with its own address
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        core[i] <= W'(i);
      end
    end else if (mem.MemWriteEn) begin
      core[addr] <= mem.MemWrData;
    end
  end
endmodule

// File: rtl/mem_access_seq.sv
// Turns one core load/store of 1-4 bytes into consecutive byte accesses on the
// memory's base+offset port; assembles/serialises little-endian words.
module mem_access_seq #(
  parameter int unsigned W  = 8,
  parameter int unsigned A  = 8,
  parameter int unsigned NB = 4
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Store,
  input  logic [A-1:0]    BaseAddr,
  input  logic [1:0]      Size,
  input  logic [W*NB-1:0] WrWord,
  output logic [W*NB-1:0] RdWord,
  output logic            Busy,
  output logic            Done,
  mem_access_seq_if.master mem
);
  import mem_seq_pkg::*;

  state_t          state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [A-1:0]    base_q, base_d;
  logic [1:0]      size_q, size_d;
  logic            store_q, store_d;
  logic [W*NB-1:0] word_q, word_d;
  logic [W*NB-1:0] rd_word_q, rd_word_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      base_q    <= '0;
      size_q    <= '0;
      store_q   <= 1'b0;
      word_q    <= '0;
      rd_word_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      base_q    <= base_d;
      size_q    <= size_d;
      store_q   <= store_d;
      word_q    <= word_d;
      rd_word_q <= rd_word_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    base_d    = base_q;
    size_d    = size_q;
    store_d   = store_q;
    word_d    = word_q;
    rd_word_d = rd_word_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = ACCESS;
          idx_d   = '0;
          base_d  = BaseAddr;
          size_d  = Size;
          store_d = Store;
          word_d  = WrWord;
          if (!Store) rd_word_d = '0;
        end
      end
      ACCESS: begin
        if (!store_q) rd_word_d[W*idx_q +: W] = mem.MemRdData;
        if (idx_q == size_q) begin
          state_d = DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory side depends only on registered state, never on Start
  always_comb begin
    RdWord         = rd_word_q;
    Busy           = (state_q != IDLE);
    Done           = (state_q == DONE);
    mem.MemAddress = '0;
    mem.MemOffset  = '0;
    mem.MemWriteEn = 1'b0;
    mem.MemWrData  = '0;
    if (state_q == ACCESS) begin
      mem.MemAddress = base_q;
      mem.MemOffset  = idx_q;
      mem.MemWriteEn = store_q;
      if (store_q) mem.MemWrData = word_q[W*idx_q +: W];
    end
  end
endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench: sequencer driving data_mem, table of load/store vectors plus
// hand-written sequences for ignored Start and mid-store reset.
module tb_mem_access_seq;
  import mem_seq_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset, mem_reset, Start, Store;
  logic [7:0]  BaseAddr;
  logic [1:0]  Size;
  logic [31:0] WrWord, RdWord;
  logic        Busy, Done;

  mem_access_seq_if #(.W(8), .A(8)) bus ();

  mem_access_seq #(.W(8), .A(8), .NB(4)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Store    (Store),
    .BaseAddr (BaseAddr),
    .Size     (Size),
    .WrWord   (WrWord),
    .RdWord   (RdWord),
    .Busy     (Busy),
    .Done     (Done),
    .mem      (bus.master)
  );

  data_mem #(.W(8), .A(8)) u_mem (
    .Clk   (Clk),
    .Reset (mem_reset),
    .mem   (bus.slave)
  );

  always #5 Clk = ~Clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        st;
    logic [7:0]  base;
    logic [1:0]  size;
    logic [31:0] wr;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [12];

  // Entered and left at a negedge while the sequencer is idle
  task automatic run_txn(input vec_t v, input int k);
    int unsigned n;
    logic [31:0] w;
    logic [7:0]  a;
    n = int'(v.size) + 1;
    w = v.wr;
    Start = 1'b1; Store = v.st; BaseAddr = v.base; Size = v.size; WrWord = v.wr;
    @(posedge Clk);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge Clk);
      check($sformatf("v%0d acc%0d busy", k, i), Busy, 1);
      check($sformatf("v%0d acc%0d done", k, i), Done, 0);
      check($sformatf("v%0d acc%0d addr", k, i), bus.MemAddress, v.base);
      check($sformatf("v%0d acc%0d off", k, i), bus.MemOffset, i);
      check($sformatf("v%0d acc%0d we", k, i), bus.MemWriteEn, v.st);
      check($sformatf("v%0d acc%0d wdata", k, i), bus.MemWrData, v.st ? w[8*i +: 8] : 8'h00);
      Start = 1'b0; BaseAddr = 8'h00; WrWord = 32'h0;
    end
    @(negedge Clk);
    check($sformatf("v%0d done pulse", k), Done, 1);
    check($sformatf("v%0d done busy", k), Busy, 1);
    check($sformatf("v%0d done we", k), bus.MemWriteEn, 0);
    @(negedge Clk);
    check($sformatf("v%0d idle done", k), Done, 0);
    check($sformatf("v%0d idle busy", k), Busy, 0);
    check($sformatf("v%0d rdword", k), RdWord, v.exp_rd);
    if (v.st) begin
      for (int unsigned b = 0; b < n; b++) begin
        a = v.base + 8'(b);
        check($sformatf("v%0d mem[%h]", k, a), u_mem.core[a], w[8*b +: 8]);
      end
    end
  endtask

  initial begin
    int done_cnt;
    int busy_cnt;

    tbl[0]  = '{1'b0, 8'h10, SZ_WORD, 32'h0,        32'h13121110};
    tbl[1]  = '{1'b1, 8'h40, SZ_WORD, 32'hDEADBEEF, 32'h13121110};
    tbl[2]  = '{1'b0, 8'h40, SZ_WORD, 32'h0,        32'hDEADBEEF};
    tbl[3]  = '{1'b0, 8'hFE, SZ_WORD, 32'h0,        32'h0100FFFE};
    tbl[4]  = '{1'b1, 8'h50, SZ_WORD, 32'hFFFFFFFF, 32'h0100FFFE};
    tbl[5]  = '{1'b0, 8'h50, SZ_WORD, 32'h0,        32'hFFFFFFFF};
    tbl[6]  = '{1'b0, 8'h20, SZ_BYTE, 32'h0,        32'h00000020};
    tbl[7]  = '{1'b1, 8'h60, SZ_HALF, 32'h0000A5B6, 32'h00000020};
    tbl[8]  = '{1'b0, 8'h5F, SZ_HALF, 32'h0,        32'h0000B65F};
    tbl[9]  = '{1'b0, 8'h01, 2'd2,    32'h0,        32'h00030201};
    tbl[10] = '{1'b1, 8'hFE, SZ_HALF, 32'h12345678, 32'h00030201};
    tbl[11] = '{1'b0, 8'hFD, SZ_WORD, 32'h0,        32'h005678FD};

    Reset = 1'b1; mem_reset = 1'b1;
    Start = 1'b0; Store = 1'b0; BaseAddr = 8'h00; Size = 2'd0; WrWord = 32'h0;
    repeat (3) @(negedge Clk);
    check("rst busy", Busy, 0);
    check("rst done", Done, 0);
    check("rst rdword", RdWord, 0);
    check("rst we", bus.MemWriteEn, 0);
    check("rst addr", bus.MemAddress, 0);
    check("rst off", bus.MemOffset, 0);
    check("rst wdata", bus.MemWrData, 0);
    Reset = 1'b0; mem_reset = 1'b0;
    @(negedge Clk);

    for (int k = 0; k < 12; k++) run_txn(tbl[k], k);

    // Start held during ACCESS and DONE must be ignored
    done_cnt = 0; busy_cnt = 0;
    Start = 1'b1; Store = 1'b1; BaseAddr = 8'h70; Size = SZ_HALF; WrWord = 32'h0000CAFE;
    @(posedge Clk);
    @(negedge Clk);
    BaseAddr = 8'h90; WrWord = 32'h55555555;
    if (Done) done_cnt++;
    @(negedge Clk);
    Start = 1'b0;
    if (Done) done_cnt++;
    @(negedge Clk);
    check("ign done cycle3", Done, 1);
    if (Done) done_cnt++;
    Start = 1'b1;
    @(negedge Clk);
    check("ign busy drop", Busy, 0);
    Start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (Done) done_cnt++;
      if (Busy) busy_cnt++;
      @(negedge Clk);
    end
    check("ign done count", done_cnt, 1);
    check("ign busy after", busy_cnt, 0);
    check("ign mem[70]", u_mem.core[8'h70], 8'hFE);
    check("ign mem[71]", u_mem.core[8'h71], 8'hCA);
    check("ign mem[90]", u_mem.core[8'h90], 8'h90);
    check("ign mem[91]", u_mem.core[8'h91], 8'h91);

    // Reset in the second store cycle aborts without rollback
    done_cnt = 0;
    Start = 1'b1; Store = 1'b1; BaseAddr = 8'h80; Size = SZ_WORD; WrWord = 32'h11223344;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    check("abort wdata0", bus.MemWrData, 8'h44);
    @(negedge Clk);
    check("abort wdata1", bus.MemWrData, 8'h33);
    Reset = 1'b1;
    @(negedge Clk);
    check("abort busy", Busy, 0);
    check("abort we", bus.MemWriteEn, 0);
    check("abort addr", bus.MemAddress, 0);
    check("abort off", bus.MemOffset, 0);
    check("abort wdata", bus.MemWrData, 0);
    check("abort rdword", RdWord, 0);
    Reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (Done) done_cnt++;
      @(negedge Clk);
    end
    check("abort no done", done_cnt, 0);
    check("abort mem[80]", u_mem.core[8'h80], 8'h44);
    check("abort mem[81]", u_mem.core[8'h81], 8'h33);
    check("abort mem[82]", u_mem.core[8'h82], 8'h82);
    check("abort mem[83]", u_mem.core[8'h83], 8'h83);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
